imm_gen_pipe: RTL and testbench

- Registered, flow-controlled immediate generator for the decode stage of the pipeline.
- Accepts a 32-bit RV instruction plus PC over a valid/ready handshake and extracts opcode, immediate class and XLEN-wide immediate. Flags illegal opcodes.
- Presents results one cycle later through a 2-entry skid buffer, so full throughput is kept while in_ready stays registered.
- Supports XLEN 32 or 64, plus a pipeline flush for branch redirects.

---
 rtl/imm_gen_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate decoder behind a 2-entry skid buffer.
// An accepted instruction is decoded combinationally and captured into the
// main or skid entry. All outputs, including in_ready, come from registers.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_imm_type,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc
);

   localparam logic [2:0] T_NONE    = 3'd0;
   localparam logic [2:0] T_I       = 3'd1;
   localparam logic [2:0] T_S       = 3'd2;
   localparam logic [2:0] T_B       = 3'd3;
   localparam logic [2:0] T_U       = 3'd4;
   localparam logic [2:0] T_J       = 3'd5;
   localparam logic [2:0] T_CSR     = 3'd6;
   localparam logic [2:0] T_ILLEGAL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [6:0]      opcode;
      logic [2:0]      imm_type;
      logic            illegal;
      logic [XLEN-1:0] pc;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // Sign-extend a 32-bit value to the datapath width.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Shift amount: one extra bit on RV64, funct7 bits never included.
   function automatic logic [XLEN-1:0] shamt(input logic [31:0] instr);
      if (XLEN == 64) begin
         return XLEN'(instr[25:20]);
      end else begin
         return XLEN'(instr[24:20]);
      end
   endfunction

   // Full decode of one instruction into an output entry.
   function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
      entry_t e;
      e.imm      = {XLEN{1'b0}};
      e.opcode   = instr[6:0];
      e.imm_type = T_NONE;
      e.illegal  = 1'b0;
      e.pc       = pc;
      case (instr[6:0])
         7'b0110011: begin
            e.imm_type = T_NONE;
         end
         7'b0010011: begin
            e.imm_type = T_I;
            if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
               e.imm = shamt(instr);
            end else begin
               e.imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
         end
         7'b0000011, 7'b1100111: begin
            e.imm_type = T_I;
            e.imm      = sext32({{20{instr[31]}}, instr[31:20]});
         end
         7'b0100011: begin
            e.imm_type = T_S;
            e.imm      = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
         end
         7'b1100011: begin
            e.imm_type = T_B;
            e.imm      = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
         end
         7'b0110111, 7'b0010111: begin
            e.imm_type = T_U;
            e.imm      = sext32({instr[31:12], 12'b0});
         end
         7'b1101111: begin
            e.imm_type = T_J;
            e.imm      = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
         end
         7'b1110011: begin
            e.imm_type = T_CSR;
            e.imm      = XLEN'(instr[31:20]);
         end
         default: begin
            e.imm_type = T_ILLEGAL;
            e.illegal  = 1'b1;
         end
      endcase
      return e;
   endfunction

   state_t r_state;
   state_t w_next;
   logic   r_in_ready;
   logic   r_out_valid;
   entry_t r_main;
   entry_t r_skid;
   entry_t w_dec;
   logic   w_accept;
   logic   w_deliver;
   logic   w_load_main_new;
   logic   w_load_main_skid;
   logic   w_load_skid;

   assign w_dec     = decode(in_instr, in_pc);
   // An instruction offered during flush is dropped, never accepted.
   assign w_accept  = in_valid && r_in_ready && !flush;
   assign w_deliver = r_out_valid && out_ready;

   // Next-state and entry-load selection for the skid buffer.
   always_comb begin
      w_next           = r_state;
      w_load_main_new  = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_next          = S_ONE;
               w_load_main_new = 1'b1;
            end else begin
               w_next = S_EMPTY;
            end
         end
         S_ONE: begin
            if (w_accept && w_deliver) begin
               w_next          = S_ONE;
               w_load_main_new = 1'b1;
            end else if (w_accept) begin
               w_next      = S_FULL;
               w_load_skid = 1'b1;
            end else if (w_deliver) begin
               w_next = S_EMPTY;
            end else begin
               w_next = S_ONE;
            end
         end
         S_FULL: begin
            if (w_deliver) begin
               w_next           = S_ONE;
               w_load_main_skid = 1'b1;
            end else begin
               w_next = S_FULL;
            end
         end
         default: begin
            w_next = S_EMPTY;
         end
      endcase
      if (flush) begin
         w_next           = S_EMPTY;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end else begin
         w_next = w_next;
      end
   end

   // State register with registered ready/valid derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next != S_FULL);
         r_out_valid <= (w_next != S_EMPTY);
      end
   end

   // Entry storage: main feeds the outputs, skid catches the overflow word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= {ENTRY_W{1'b0}};
         r_skid <= {ENTRY_W{1'b0}};
      end else begin
         if (w_load_main_new) begin
            r_main <= w_dec;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end else begin
            r_main <= r_main;
         end
         if (w_load_skid) begin
            r_skid <= w_dec;
         end else begin
            r_skid <= r_skid;
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_imm      = r_main.imm;
   assign out_opcode   = r_main.opcode;
   assign out_imm_type = r_main.imm_type;
   assign out_illegal  = r_main.illegal;
   assign out_pc       = r_main.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
// Accepted words are pushed to per-width expectation queues; a negedge
// monitor checks valid/ready against queue occupancy and pops on delivery.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        in_ready32, out_valid32, out_ill32;
   logic [31:0] out_imm32, out_pc32;
   logic [6:0]  out_op32;
   logic [2:0]  out_ty32;
   logic        in_ready64, out_valid64, out_ill64;
   logic [63:0] out_imm64, out_pc64;
   logic [6:0]  out_op64;
   logic [2:0]  out_ty64;

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_opcode(out_op32), .out_imm_type(out_ty32),
      .out_illegal(out_ill32), .out_pc(out_pc32));

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_opcode(out_op64), .out_imm_type(out_ty64),
      .out_illegal(out_ill64), .out_pc(out_pc64));

   typedef struct {
      logic [63:0] imm;
      logic [6:0]  op;
      logic [2:0]  ty;
      logic        ill;
      logic [63:0] pc;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   checks = 0;
   int   errors = 0;
   bit   chk_zero = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Unsigned bit field instr[hi:lo] as a number.
   function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
      return longint'((x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
   endfunction

   // Reference immediate: fields weighted arithmetically, sign bit subtracted.
   function automatic logic [63:0] model(input logic [31:0] ins, input int xlen, output logic [2:0] ty);
      longint v = 0;
      longint s = ins[31] ? 64'sd1 : 64'sd0;
      case (ins[6:0])
         7'b0110011: begin ty = 3'd0; v = 0; end
         7'b0010011: begin
            ty = 3'd1;
            if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101)
               v = (xlen == 64) ? fld(ins, 25, 20) : fld(ins, 24, 20);
            else
               v = fld(ins, 31, 20) - s * 4096;
         end
         7'b0000011, 7'b1100111: begin ty = 3'd1; v = fld(ins, 31, 20) - s * 4096; end
         7'b0100011: begin ty = 3'd2; v = fld(ins, 31, 25) * 32 + fld(ins, 11, 7) - s * 4096; end
         7'b1100011: begin
            ty = 3'd3;
            v = fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2 - s * 4096;
         end
         7'b0110111, 7'b0010111: begin ty = 3'd4; v = fld(ins, 31, 12) * 4096 - s * (64'sd1 << 32); end
         7'b1101111: begin
            ty = 3'd5;
            v = fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2 - s * (64'sd1 << 20);
         end
         7'b1110011: begin ty = 3'd6; v = fld(ins, 31, 20); end
         default: begin ty = 3'd7; v = 0; end
      endcase
      if (xlen == 32) return {32'd0, v[31:0]};
      return v;
   endfunction

   task automatic push(input logic [31:0] ins, input logic [63:0] pc);
      exp_t e;
      e.op  = ins[6:0];
      e.imm = model(ins, 32, e.ty);
      e.ill = (e.ty == 3'd7);
      e.pc  = {32'd0, pc[31:0]};
      q32.push_back(e);
      e.imm = model(ins, 64, e.ty);
      e.pc  = pc;
      q64.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl, input logic r);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
   endtask

   // Wait for the sampling edge, record an accept, then leave room to drive.
   task automatic tick(output bit acc);
      @(posedge clk);
      acc = !rst && !flush && in_valid && in_ready32;
      if (acc) push(in_instr, in_pc);
      #1;
   endtask

   task automatic mon(input int w, input logic ov, input logic ir, input logic [63:0] imm,
                      input logic [6:0] op, input logic [2:0] ty, input logic ill, input logic [63:0] pc);
      int   sz;
      exp_t e;
      sz = (w == 32) ? q32.size() : q64.size();
      if (chk_zero) begin
         chk($sformatf("rst_imm%0d", w), imm, 64'd0);
         chk($sformatf("rst_op%0d", w), {57'd0, op}, 64'd0);
         chk($sformatf("rst_ty%0d", w), {61'd0, ty}, 64'd0);
         chk($sformatf("rst_ill%0d", w), {63'd0, ill}, 64'd0);
         chk($sformatf("rst_pc%0d", w), pc, 64'd0);
      end
      chk($sformatf("out_valid%0d", w), {63'd0, ov}, {63'd0, sz > 0});
      chk($sformatf("in_ready%0d", w), {63'd0, ir}, {63'd0, sz < 2});
      if (!rst && ov && out_ready) begin
         if (sz == 0) begin
            chk($sformatf("spurious_out%0d", w), 64'd1, 64'd0);
         end else begin
            if (w == 32) e = q32.pop_front();
            else e = q64.pop_front();
            chk($sformatf("imm%0d", w), imm, e.imm);
            chk($sformatf("opcode%0d", w), {57'd0, op}, {57'd0, e.op});
            chk($sformatf("type%0d", w), {61'd0, ty}, {61'd0, e.ty});
            chk($sformatf("illegal%0d", w), {63'd0, ill}, {63'd0, e.ill});
            chk($sformatf("pc%0d", w), pc, e.pc);
         end
      end
   endtask

   // Monitor: compare at negedge, consume on delivery, clear on flush/reset.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         mon(32, out_valid32, in_ready32, {32'd0, out_imm32}, out_op32, out_ty32, out_ill32, {32'd0, out_pc32});
         mon(64, out_valid64, in_ready64, out_imm64, out_op64, out_ty64, out_ill64, out_pc64);
         chk_zero = 1'b0;
         if (rst) begin
            q32.delete();
            q64.delete();
            chk_zero = 1'b1;
         end else if (flush) begin
            q32.delete();
            q64.delete();
         end
      end
   end

   logic [31:0] dir_words [8] = '{32'hFFF00093, 32'h41F0D093, 32'h03F09093, 32'hFE000EE3,
                                  32'h800000B7, 32'h00000000, 32'h0000007F, 32'h00C0006F};
   logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                            7'h6F, 7'h73, 7'h13, 7'h00};

   initial begin
      bit          acc;
      bit          acc3;
      logic [31:0] r;
      logic [6:0]  op;
      int          n;

      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      tick(acc);
      tick(acc);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      tick(acc);

      // Directed decode words, back-to-back with out_ready high.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, dir_words[i], 64'h8000_0000_0000_1000 + 64'(i * 4), 1'b1, 1'b0, 1'b0);
         tick(acc);
         chk("directed_accept", {63'd0, acc}, 64'd1);
      end
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(acc);

      // Stall: two words fill the buffer, the third is held upstream.
      drive(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0, 1'b0); tick(acc);
      drive(1'b1, 32'h00200093, 64'h2004, 1'b0, 1'b0, 1'b0); tick(acc);
      drive(1'b1, 32'h00300093, 64'h2008, 1'b0, 1'b0, 1'b0); tick(acc3);
      chk("third_word_held", {63'd0, acc3}, 64'd0);
      drive(1'b1, 32'h00300093, 64'h2008, 1'b1, 1'b0, 1'b0);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 10) begin
         tick(acc);
         n++;
      end
      chk("third_word_accepted", {63'd0, acc}, 64'd1);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(acc);

      // Flush from FULL with a word offered in the same cycle.
      drive(1'b1, 32'h00A00093, 64'h3000, 1'b0, 1'b0, 1'b0); tick(acc);
      drive(1'b1, 32'h00B00093, 64'h3004, 1'b0, 1'b0, 1'b0); tick(acc);
      drive(1'b1, 32'h00C00093, 64'h3008, 1'b0, 1'b1, 1'b0); tick(acc);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(acc);

      // Reset mid-stream with an entry waiting.
      drive(1'b1, 32'h00D00093, 64'h4000, 1'b0, 1'b0, 1'b0); tick(acc);
      drive(1'b1, 32'h00E00093, 64'h4004, 1'b0, 1'b0, 1'b1); tick(acc);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(acc);

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom();
         op = ops[$urandom_range(0, 11)];
         if (op == 7'h00) op = r[6:0];
         drive(($urandom() % 4) != 0, {r[31:7], op}, {$urandom(), $urandom()},
               ($urandom() % 3) != 0, ($urandom() % 40) == 0, ($urandom() % 200) == 0);
         tick(acc);
      end

      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(acc);
      chk("drained", 64'(q32.size() + q64.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
